// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver.
// Each digit slot is an all-dark guard interval followed by a drive interval.
// Loaded values sit in a pending buffer and are promoted to the active buffer
// only on the edge that wraps the scan back to digit 0, so a frame never mixes
// old and new digits.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? (GUARD_CYC - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // With no guard interval the scan lives permanently in DRIVE.
    localparam state_e RESET_STATE = (GUARD_CYC == 0) ? ST_DRIVE : ST_GUARD;

    // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  boundary_s;

    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]     pend_blank_q, pend_blank_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0]   act_val_q, act_val_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [DIGITS-1:0]     act_blank_q, act_blank_d;

    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic [3:0]            sel_nib_s;
    logic                  sel_dp_s;
    logic                  sel_blank_s;

    // Slot sequencer: guard/drive phase, cycle counter and digit index.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        boundary_s = 1'b0;
        case (state_q)
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RESET_STATE;
                    if (idx_q == IDX_LAST) begin
                        idx_d      = {IDX_W{1'b0}};
                        boundary_s = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = {CNT_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Double buffer: loads go to pending, promotion to active only at the frame boundary.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
        end else begin
            pend_val_d   = pend_val_q;
        end
        if (boundary_s) begin
            pend_valid_d = 1'b0;
            if (load) begin
                // A load in the boundary cycle bypasses pending and shows this frame.
                act_val_d   = value;
                act_dp_d    = dp_in;
                act_blank_d = blank_in;
            end else if (pend_valid_q) begin
                act_val_d   = pend_val_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
            end else begin
                act_val_d   = act_val_q;
            end
        end else if (load) begin
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Pick the active-buffer fields of the digit that will be scanned next cycle.
    always_comb begin
        sel_nib_s   = 4'h0;
        sel_dp_s    = 1'b0;
        sel_blank_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_nib_s   = act_val_d[4*i +: 4];
                sel_dp_s    = act_dp_d[i];
                sel_blank_s = act_blank_d[i];
            end else begin
                sel_nib_s   = sel_nib_s;
            end
        end
    end

    // Output image for the next cycle; only one anode can ever be driven low.
    always_comb begin
        an_d         = {DIGITS{1'b1}};
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = boundary_s;
        if ((state_d == ST_DRIVE) && !sel_blank_s) begin
            an_d  = ~(DIGITS'(1) << idx_d);
            seg_d = hex_to_seg(sel_nib_s);
            dp_d  = ~sel_dp_s;
        end else begin
            an_d  = {DIGITS{1'b1}};
        end
    end

    // State, buffer and output registers; reset blanks the display at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RESET_STATE;
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            pend_val_q   <= {(4*DIGITS){1'b0}};
            pend_dp_q    <= {DIGITS{1'b0}};
            pend_blank_q <= {DIGITS{1'b0}};
            pend_valid_q <= 1'b0;
            act_val_q    <= {(4*DIGITS){1'b0}};
            act_dp_q     <= {DIGITS{1'b0}};
            act_blank_q  <= {DIGITS{1'b0}};
            an_q         <= {DIGITS{1'b1}};
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
